// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter with byte FIFO and back-to-back framing
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              uart_tx,
    output logic              busy,
    output logic [ADDR_W:0]   fifo_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]  FULL_CNT  = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  bit_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              push;
    logic              pop;
    logic              not_empty;
    logic              bit_done;

    assign tx_ready  = (fifo_count != FULL_CNT);
    assign push      = tx_valid & tx_ready;
    assign not_empty = (fifo_count != '0);
    assign bit_done  = (bit_cnt == BIT_LAST);
    // A byte leaves the FIFO only when the serialiser is ready to start a new frame.
    assign pop       = not_empty & ((state == IDLE) | ((state == STOP) & bit_done));
    assign busy      = (state != IDLE) | not_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            uart_tx <= 1'b1;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    bit_cnt <= '0;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        uart_tx <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        uart_tx <= shift[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            // Line takes the next bit from the pre-shift value so it is registered.
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            uart_tx <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            shift   <= mem[rd_ptr];
                            uart_tx <= 1'b0;
                            state   <= START;
                        end else begin
                            uart_tx <= 1'b1;
                            state   <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
